// File: rtl/store_buffer_if.sv
// Request and data_memory bus for store_buffer. The slave side is the buffer;
// the master side is the execute stage together with data_memory.
interface store_buffer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmctrl;
  logic [31:0] ld_data;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_dmctrl;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        sb_empty;
  logic        misalign_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_dmctrl, mem_rdata,
    input  req_ready, ld_data, mem_address, mem_wdata, mem_dmctrl, mem_write,
           sb_empty, misalign_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_dmctrl, mem_rdata,
    output req_ready, ld_data, mem_address, mem_wdata, mem_dmctrl, mem_write,
           sb_empty, misalign_err
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of data_memory with exact-match load forwarding.
// Optional STORE_BUFFER_MISALIGN_TRAP_EN drops misaligned H/W requests and pulses misalign_err.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [2:0]    ent_ctrl [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, yng;
  logic [AW:0]   count;

  logic ctrl_ok, misaligned, live, hit, fwd_ok, load_port, enq, pop;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] c);
    case (c)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b010:  return d;
      3'b100:  return {24'b0, d[7:0]};
      3'b101:  return {16'b0, d[15:0]};
      default: return '0;
    endcase
  endfunction

  assign ctrl_ok = bus.req_dmctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

`ifdef STORE_BUFFER_MISALIGN_TRAP_EN
  assign misaligned = ctrl_ok &&
                      ((bus.req_dmctrl[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_dmctrl[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Ascending scan from the head, so the last match is the youngest store to the word.
  always_comb begin
    hit = 1'b0;
    yng = rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < count &&
          ent_addr[rd_ptr + AW'(k)][31:2] == bus.req_addr[31:2]) begin
        hit = 1'b1;
        yng = rd_ptr + AW'(k);
      end
    end
  end

  assign live      = bus.req_valid && ctrl_ok && !misaligned;
  assign fwd_ok    = hit && ent_addr[yng] == bus.req_addr &&
                     ent_ctrl[yng][1:0] == bus.req_dmctrl[1:0];
  assign load_port = live && !bus.req_write && !hit;
  assign enq       = live && bus.req_write && count != FULL;
  assign pop       = count != '0 && !load_port;

  always_comb begin
    bus.req_ready = 1'b0;
    bus.ld_data   = '0;
    if (bus.req_valid) begin
      if (!live)
        bus.req_ready = 1'b1;
      else if (bus.req_write)
        bus.req_ready = count != FULL;
      else if (!hit) begin
        bus.req_ready = 1'b1;
        bus.ld_data   = bus.mem_rdata;
      end else if (fwd_ok) begin
        bus.req_ready = 1'b1;
        bus.ld_data   = extend(ent_data[yng], bus.req_dmctrl);
      end
    end
  end

  always_comb begin
    bus.mem_address = ent_addr[rd_ptr];
    bus.mem_wdata   = ent_data[rd_ptr];
    bus.mem_dmctrl  = ent_ctrl[rd_ptr];
    bus.mem_write   = pop;
    if (load_port) begin
      bus.mem_address = bus.req_addr;
      bus.mem_wdata   = '0;
      bus.mem_dmctrl  = bus.req_dmctrl;
    end
  end

  assign bus.sb_empty = (count == '0);

  // Payload storage needs no reset: occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= bus.req_addr;
      ent_data[wr_ptr] <= bus.req_wdata;
      ent_ctrl[wr_ptr] <= bus.req_dmctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({enq, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef STORE_BUFFER_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= bus.req_valid && misaligned;
  end
  assign bus.misalign_err = mis_q;
`else
  assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer: an architectural memory plus a pending-store queue
// predict every output each cycle; directed sequences pin the model with literal values.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  ctrl;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if bus();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] dmem [256];   // data_memory contents
  logic [7:0] gold [256];   // memory as the program sees it (all accepted stores applied)
  st_t        pend [$];     // accepted stores not yet written to data_memory
  logic       mis_prev = 1'b0;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] c);
    case (c)
      3'b000:  return 32'($signed(w[7:0]));
      3'b001:  return 32'($signed(w[15:0]));
      3'b010:  return w;
      3'b100:  return 32'(w[7:0]);
      3'b101:  return 32'(w[15:0]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] c);
    return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : (c[1:0] == 2'b10) ? 4 : 0;
  endfunction

  function automatic logic [31:0] gold_read(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = gold[8'(a + 32'(i))];
    return ext(w, c);
  endfunction

  function automatic logic [31:0] dmem_word(input logic [7:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = dmem[a + 8'(i)];
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // data_memory: combinational read, write on the clock edge
  always_comb begin
    logic [31:0] raw;
    for (int i = 0; i < 4; i++) raw[8*i +: 8] = dmem[bus.mem_address[7:0] + 8'(i)];
    bus.mem_rdata = ext(raw, bus.mem_dmctrl);
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_write)
      for (int i = 0; i < nbytes(bus.mem_dmctrl); i++)
        dmem[bus.mem_address[7:0] + 8'(i)] <= bus.mem_wdata[8*i +: 8];
  end

  function automatic logic is_mis(input logic [31:0] a, input logic [2:0] c);
`ifdef STORE_BUFFER_MISALIGN_TRAP_EN
    return (c == 3'b001 || c == 3'b101) ? a[0] : (c == 3'b010) ? (a[1:0] != 2'b00) : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Compare process: predicts outputs for the current request, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      gold     = dmem;
      mis_prev = 1'b0;
    end else begin
      logic vc, mis, port_load, exp_ready, exp_mw;
      logic [31:0] exp_ld;
      int y;
      vc        = bus.req_dmctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      mis       = bus.req_valid && vc && is_mis(bus.req_addr, bus.req_dmctrl);
      port_load = 1'b0;
      exp_ready = 1'b1;
      exp_ld    = 32'h0;
      chk("sb_empty", 32'(bus.sb_empty), 32'(pend.size() == 0));
      chk("misalign_err", 32'(bus.misalign_err), 32'(mis_prev));
      if (bus.req_valid) begin
        if (!vc || mis) begin
          exp_ready = 1'b1;
        end else if (bus.req_write) begin
          exp_ready = pend.size() < DEPTH;
        end else begin
          y = -1;
          for (int i = 0; i < pend.size(); i++)
            if (pend[i].addr[31:2] == bus.req_addr[31:2]) y = i;
          if (y < 0) begin
            port_load = 1'b1;
            exp_ld    = gold_read(bus.req_addr, bus.req_dmctrl);
          end else if (pend[y].addr == bus.req_addr &&
                       pend[y].ctrl[1:0] == bus.req_dmctrl[1:0]) begin
            exp_ld = gold_read(bus.req_addr, bus.req_dmctrl);
          end else begin
            exp_ready = 1'b0;
          end
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (!bus.req_write && exp_ready) chk("ld_data", bus.ld_data, exp_ld);
      end
      exp_mw = pend.size() > 0 && !port_load;
      chk("mem_write", 32'(bus.mem_write), 32'(exp_mw));
      if (exp_mw) begin
        chk("drain_addr", bus.mem_address, pend[0].addr);
        chk("drain_data", bus.mem_wdata, pend[0].data);
        chk("drain_ctrl", 32'(bus.mem_dmctrl), 32'(pend[0].ctrl));
      end
      if (port_load) begin
        chk("load_addr", bus.mem_address, bus.req_addr);
        chk("load_ctrl", 32'(bus.mem_dmctrl), 32'(bus.req_dmctrl));
      end
      if (exp_mw) void'(pend.pop_front());
      if (bus.req_valid && bus.req_write && vc && !mis && exp_ready) begin
        pend.push_back('{addr: bus.req_addr, data: bus.req_wdata, ctrl: bus.req_dmctrl});
        for (int i = 0; i < nbytes(bus.req_dmctrl); i++)
          gold[8'(bus.req_addr + 32'(i))] = bus.req_wdata[8*i +: 8];
      end
      mis_prev = mis;
    end
  end

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] c);
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_dmctrl = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] saved;
    logic [2:0]  ctrls [6];
    logic [2:0]  c;
    logic [31:0] a;
    ctrls = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
    for (int i = 8'h80; i < 8'h98; i++) dmem[i] = 8'h00;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("reset_mem_write", 32'(bus.mem_write), 32'd0);
    chk("reset_misalign", 32'(bus.misalign_err), 32'd0);

    // SW into empty buffer, drained on the next cycle
    next_cycle();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    @(negedge clk) chk("t1_ready", 32'(bus.req_ready), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    chk("t1_mem_write", 32'(bus.mem_write), 32'd1);
    chk("t1_mem_address", bus.mem_address, 32'h10);
    chk("t1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk) chk("t1_empty_after", 32'(bus.sb_empty), 32'd1);

    // SB then LB forwarded with sign extension, LBU zero-extended
    next_cycle();
    drive(1'b1, 1'b1, 32'h21, 32'h80, 3'b000);
    next_cycle();
    drive(1'b1, 1'b0, 32'h21, 32'h0, 3'b000);
    @(negedge clk) chk("t2_lb", bus.ld_data, 32'hFFFFFF80);
    next_cycle();
    drive(1'b1, 1'b0, 32'h21, 32'h0, 3'b100);
    @(negedge clk) chk("t2_lbu", bus.ld_data, 32'h00000080);

    // partial overlap stalls until the store drains
    next_cycle();
    drive(1'b1, 1'b1, 32'h40, 32'h11223344, 3'b010);
    next_cycle();
    drive(1'b1, 1'b0, 32'h41, 32'h0, 3'b000);
    @(negedge clk) chk("t3_stall", 32'(bus.req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t3_ready", 32'(bus.req_ready), 32'd1);
    chk("t3_ld", bus.ld_data, 32'h00000033);

    // DEPTH+1 back-to-back stores drain in order across the pointer wrap
    for (int i = 0; i <= DEPTH; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, 32'h80 + 32'(4 * i), 32'hA0000000 + 32'(i), 3'b010);
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    repeat (2) next_cycle();
    chk("t4_last_word", dmem_word(8'h90), 32'hA0000004);
    chk("t4_first_word", dmem_word(8'h80), 32'hA0000000);

    // reset with a store still buffered loses it
    saved = dmem_word(8'h30);
    drive(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    rst = 1'b1;
    #1;
    chk("t5_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("t5_mem_write", 32'(bus.mem_write), 32'd0);
    next_cycle();
    rst = 1'b0;
    repeat (2) next_cycle();
    chk("t5_no_write", dmem_word(8'h30), saved);

`ifdef STORE_BUFFER_MISALIGN_TRAP_EN
    drive(1'b1, 1'b1, 32'h42, 32'h55667788, 3'b010);
    @(negedge clk) chk("t6_ready", 32'(bus.req_ready), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    chk("t6_pulse", 32'(bus.misalign_err), 32'd1);
    chk("t6_not_enqueued", 32'(bus.sb_empty), 32'd1);
    next_cycle();
    @(negedge clk) chk("t6_pulse_end", 32'(bus.misalign_err), 32'd0);
`endif

    // random traffic in a small window so overlaps are frequent
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      c = ($urandom_range(0, 19) == 0) ? ctrls[5] : ctrls[$urandom_range(0, 4)];
      a = 32'hC0 + 32'($urandom_range(0, 7) * 4);
      case (c[1:0])
        2'b00:   a = a + 32'($urandom_range(0, 3));
        2'b01:   a = a + 32'($urandom_range(0, 1) * 2);
        2'b10:   a = a;
        default: a = a + 32'($urandom_range(0, 3));
      endcase
      drive($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, c);
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
